// File: rtl/fifo_multi_checker.sv
// Shadow-models n_ch FIFOs and reports overflow, underflow, flag and data
// errors per channel, plus shared first-error capture and an error-cycle count.
module fifo_multi_checker #(
  parameter int width = 8,
  parameter int depth = 4,
  parameter int n_ch = 2,
  parameter bit allow_push_when_full_with_pop = 1'b0,
  parameter bit strict = 1'b0,
  parameter int cnt_w = 8,
  localparam int CH_W = (n_ch > 1) ? $clog2(n_ch) : 1,
  localparam int LVL_W = $clog2(depth + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [n_ch-1:0]          push,
  input  logic [n_ch-1:0]          pop,
  input  logic [n_ch*width-1:0]    write_data,
  input  logic [n_ch*width-1:0]    read_data,
  input  logic [n_ch-1:0]          empty,
  input  logic [n_ch-1:0]          full,
  output logic [n_ch*5-1:0]        err_flags,
  output logic [n_ch-1:0]          err_sticky,
  output logic                     first_err_valid,
  output logic [CH_W-1:0]          first_err_ch,
  output logic [4:0]               first_err_code,
  output logic [cnt_w-1:0]         err_count,
  output logic [n_ch*LVL_W-1:0]    level
);

  localparam int PTR_W = $clog2(depth);

  // Relies on the FPGA power-up value of 0: nothing is checked until the first rst.
  logic armed_q, armed_d;

  logic [n_ch*5-1:0] err_now;
  logic [n_ch*5-1:0] err_flags_q, err_flags_d;
  logic [n_ch-1:0]   err_sticky_q, err_sticky_d;
  logic              first_err_valid_q, first_err_valid_d;
  logic [CH_W-1:0]   first_err_ch_q, first_err_ch_d;
  logic [4:0]        first_err_code_q, first_err_code_d;
  logic [cnt_w-1:0]  err_count_q, err_count_d;
  logic              any_err;
  logic [CH_W-1:0]   cand_ch;
  logic [4:0]        cand_code;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(depth - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar gi = 0; gi < n_ch; gi++) begin : g_ch
    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [width-1:0] wdata, rdata, head;
    logic             is_zero, is_full, do_push, do_pop;
    logic [4:0]       err_c;

    assign wdata = write_data[gi*width +: width];
    assign rdata = read_data[gi*width +: width];

    always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      head     = mem_q[rd_ptr_q];
      is_zero  = (count_q == '0);
      is_full  = (count_q == LVL_W'(depth));

      // Checks see the model as it stood before this edge's update.
      err_c    = '0;
      err_c[0] = push[gi] & full[gi] & ~(pop[gi] & allow_push_when_full_with_pop);
      err_c[1] = pop[gi] & empty[gi];
      err_c[2] = (is_zero & ~empty[gi]) | (strict & ~is_zero & empty[gi]);
      err_c[3] = (is_full & ~full[gi]) | (strict & ~is_full & full[gi]);
      err_c[4] = ~empty[gi] & ~is_zero & (rdata != head);
      if (!armed_q) err_c = '0;

      do_pop  = armed_q & pop[gi] & ~is_zero;
      do_push = armed_q & push[gi] & (~is_full | (pop[gi] & ~is_zero));

      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
      end
    end

    assign err_now[gi*5 +: 5]         = err_c;
    assign level[gi*LVL_W +: LVL_W]   = armed_q ? count_q : '0;
  end

  always_comb begin
    armed_d           = armed_q | rst;
    err_flags_d       = err_now;
    err_sticky_d      = err_sticky_q;
    first_err_valid_d = first_err_valid_q;
    first_err_ch_d    = first_err_ch_q;
    first_err_code_d  = first_err_code_q;
    err_count_d       = err_count_q;
    any_err           = 1'b0;
    cand_ch           = '0;
    cand_code         = '0;

    // Descending scan so the lowest-numbered erring channel is left as candidate.
    for (int c = n_ch - 1; c >= 0; c--) begin
      if (err_now[c*5 +: 5] != 5'd0) begin
        any_err   = 1'b1;
        cand_ch   = CH_W'(c);
        cand_code = err_now[c*5 +: 5];
      end
      err_sticky_d[c] = err_sticky_q[c] | (|err_now[c*5 +: 5]);
    end

    if (any_err && !first_err_valid_q) begin
      first_err_valid_d = 1'b1;
      first_err_ch_d    = cand_ch;
      first_err_code_d  = cand_code;
    end
    if (any_err && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    armed_q <= armed_d;
    if (rst) begin
      err_flags_q       <= '0;
      err_sticky_q      <= '0;
      first_err_valid_q <= 1'b0;
      first_err_ch_q    <= '0;
      first_err_code_q  <= '0;
      err_count_q       <= '0;
    end else begin
      err_flags_q       <= err_flags_d;
      err_sticky_q      <= err_sticky_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_ch_q    <= first_err_ch_d;
      first_err_code_q  <= first_err_code_d;
      err_count_q       <= err_count_d;
    end
  end

  assign err_flags       = armed_q ? err_flags_q : '0;
  assign err_sticky      = armed_q ? err_sticky_q : '0;
  assign first_err_valid = armed_q & first_err_valid_q;
  assign first_err_ch    = armed_q ? first_err_ch_q : '0;
  assign first_err_code  = armed_q ? first_err_code_q : '0;
  assign err_count       = armed_q ? err_count_q : '0;

endmodule

// File: tb/tb_fifo_multi_checker.sv
// Bench for fifo_multi_checker: three configurations share one stimulus stream
// and are compared every cycle against a queue-based behavioural model.
module tb_fifo_multi_checker;

  localparam int ND = 3;

  function automatic int dep_of(input int d);
    return (d == 2) ? 5 : 4;
  endfunction
  function automatic bit allow_of(input int d);
    return (d == 1);
  endfunction
  function automatic bit strict_of(input int d);
    return (d == 1);
  endfunction
  function automatic int cmax_of(input int d);
    return (d == 1) ? 3 : 255;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  push = '0, pop = '0, emp = 2'b11, ful = '0;
  logic [15:0] wd = '0, rd = '0;

  logic [9:0] ef_a, ef_b, ef_c;
  logic [1:0] es_a, es_b, es_c;
  logic       fv_a, fv_b, fv_c;
  logic       fch_a, fch_b, fch_c;
  logic [4:0] fc_a, fc_b, fc_c;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;
  logic [5:0] lv_a, lv_b, lv_c;

  always #5 clk = ~clk;

  fifo_multi_checker #(.width(8), .depth(4), .n_ch(2), .allow_push_when_full_with_pop(1'b0),
                       .strict(1'b0), .cnt_w(8)) dut_a (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .write_data(wd), .read_data(rd),
    .empty(emp), .full(ful), .err_flags(ef_a), .err_sticky(es_a), .first_err_valid(fv_a),
    .first_err_ch(fch_a), .first_err_code(fc_a), .err_count(cnt_a), .level(lv_a));

  fifo_multi_checker #(.width(8), .depth(4), .n_ch(2), .allow_push_when_full_with_pop(1'b1),
                       .strict(1'b1), .cnt_w(2)) dut_b (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .write_data(wd), .read_data(rd),
    .empty(emp), .full(ful), .err_flags(ef_b), .err_sticky(es_b), .first_err_valid(fv_b),
    .first_err_ch(fch_b), .first_err_code(fc_b), .err_count(cnt_b), .level(lv_b));

  fifo_multi_checker #(.width(8), .depth(5), .n_ch(2), .allow_push_when_full_with_pop(1'b0),
                       .strict(1'b0), .cnt_w(8)) dut_c (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .write_data(wd), .read_data(rd),
    .empty(emp), .full(ful), .err_flags(ef_c), .err_sticky(es_c), .first_err_valid(fv_c),
    .first_err_ch(fch_c), .first_err_code(fc_c), .err_count(cnt_c), .level(lv_c));

  // Behavioural model: one queue per (config, channel) plus expected outputs.
  logic [7:0] mq [ND*2][$];
  bit         armed [ND];
  logic [9:0] x_ef [ND];
  logic [1:0] x_es [ND];
  logic       x_fv [ND];
  logic       x_fch [ND];
  logic [4:0] x_fc [ND];
  int         x_cnt [ND];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cfg%0d: got=0x%0h expected=0x%0h at t=%0t", name, d, got, exp, $time);
    end
  endtask

  task automatic lit(input string name, input int d, input logic [31:0] dutv,
                     input logic [31:0] modv, input logic [31:0] want);
    chk({name, "_dut"}, d, dutv, want);
    chk({name, "_model"}, d, modv, want);
  endtask

  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      logic [9:0] nf;
      bit any;
      if (rst) begin
        for (int c = 0; c < 2; c++) mq[d*2+c].delete();
        armed[d] = 1'b1;
        x_ef[d] = '0; x_es[d] = '0; x_fv[d] = 1'b0; x_fch[d] = 1'b0; x_fc[d] = '0; x_cnt[d] = 0;
      end else if (armed[d]) begin
        nf = '0;
        any = 1'b0;
        for (int c = 0; c < 2; c++) begin
          int occ;
          logic [4:0] e;
          logic [7:0] head;
          occ  = mq[d*2+c].size();
          head = (occ > 0) ? mq[d*2+c][0] : 8'h00;
          e[0] = push[c] && ful[c] && !(pop[c] && allow_of(d));
          e[1] = pop[c] && emp[c];
          e[2] = (occ == 0 && !emp[c]) || (strict_of(d) && occ != 0 && emp[c]);
          e[3] = (occ == dep_of(d) && !ful[c]) || (strict_of(d) && occ != dep_of(d) && ful[c]);
          e[4] = !emp[c] && occ != 0 && (rd[c*8 +: 8] != head);
          nf[c*5 +: 5] = e;
          if (e != 5'd0) begin
            any = 1'b1;
            x_es[d][c] = 1'b1;
            if (!x_fv[d]) begin
              x_fv[d] = 1'b1; x_fch[d] = 1'(c); x_fc[d] = e;
            end
          end
          if (pop[c] && occ > 0) void'(mq[d*2+c].pop_front());
          if (push[c] && (occ < dep_of(d) || (pop[c] && occ > 0))) mq[d*2+c].push_back(wd[c*8 +: 8]);
        end
        x_ef[d] = nf;
        if (any && x_cnt[d] < cmax_of(d)) x_cnt[d]++;
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [9:0] g_ef, input logic [1:0] g_es,
                           input logic g_fv, input logic g_fch, input logic [4:0] g_fc,
                           input logic [7:0] g_cnt, input logic [5:0] g_lv);
    chk("err_flags", d, 32'(g_ef), 32'(x_ef[d]));
    chk("err_sticky", d, 32'(g_es), 32'(x_es[d]));
    chk("first_err_valid", d, 32'(g_fv), 32'(x_fv[d]));
    chk("first_err_ch", d, 32'(g_fch), 32'(x_fch[d]));
    chk("first_err_code", d, 32'(g_fc), 32'(x_fc[d]));
    chk("err_count", d, 32'(g_cnt), 32'(x_cnt[d]));
    for (int c = 0; c < 2; c++) chk("level", d, 32'(g_lv[c*3 +: 3]), 32'(mq[d*2+c].size()));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_dut(0, ef_a, es_a, fv_a, fch_a, fc_a, cnt_a, lv_a);
    check_dut(1, ef_b, es_b, fv_b, fch_b, fc_b, {6'd0, cnt_b}, lv_b);
    check_dut(2, ef_c, es_c, fv_c, fch_c, fc_c, cnt_c, lv_c);
  endtask

  task automatic step(input string name, input logic [1:0] ps, input logic [1:0] pp,
                      input logic [15:0] w, input logic [15:0] r, input logic [1:0] e, input logic [1:0] f);
    push = ps; pop = pp; wd = w; rd = r; emp = e; ful = f;
    $display("txn %s: rst=%0b push=%b pop=%b wd=%h rd=%h empty=%b full=%b", name, rst, ps, pp, w, r, e, f);
    cycle();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step("reset", 2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 2'b00);
    rst = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      armed[d] = 1'b0; x_ef[d] = '0; x_es[d] = '0; x_fv[d] = 1'b0;
      x_fch[d] = 1'b0; x_fc[d] = '0; x_cnt[d] = 0;
    end
    @(negedge clk);

    // Traffic before any reset must be ignored.
    step("prearm", 2'b11, 2'b00, 16'h1234, 16'h5678, 2'b00, 2'b11);
    step("prearm", 2'b01, 2'b11, 16'h9abc, 16'h0000, 2'b11, 2'b00);
    lit("prearm_valid", 0, 32'(fv_a), 32'(x_fv[0]), 0);
    lit("prearm_level", 0, 32'(lv_a), 32'(mq[0].size()), 0);

    do_rst();
    step("r039_push", 2'b01, 2'b00, 16'h00A1, 16'h0000, 2'b11, 2'b00);
    step("r039_push", 2'b01, 2'b00, 16'h00A2, 16'h00A1, 2'b10, 2'b00);
    step("r039_push", 2'b01, 2'b00, 16'h00A3, 16'h00A1, 2'b10, 2'b00);
    lit("r039_level", 0, 32'(lv_a[2:0]), 32'(mq[0].size()), 3);
    lit("r039_flags", 0, 32'(ef_a), 32'(x_ef[0]), 0);

    step("r040_fill", 2'b01, 2'b00, 16'h00A4, 16'h00A1, 2'b10, 2'b00);
    step("r040_ovf", 2'b01, 2'b00, 16'h0055, 16'h00A1, 2'b10, 2'b01);
    lit("r040_flags", 0, 32'(ef_a), 32'(x_ef[0]), 32'h001);
    lit("r040_fch", 0, 32'(fch_a), 32'(x_fch[0]), 0);
    lit("r040_fcode", 0, 32'(fc_a), 32'(x_fc[0]), 32'h01);
    lit("r040_count", 0, 32'(cnt_a), 32'(x_cnt[0]), 1);
    lit("r040_level", 0, 32'(lv_a[2:0]), 32'(mq[0].size()), 4);

    do_rst();
    step("r041_push", 2'b10, 2'b00, 16'h1000, 16'h0000, 2'b11, 2'b00);
    step("r041_bad", 2'b00, 2'b00, 16'h0000, 16'h1100, 2'b01, 2'b00);
    lit("r041_flags", 0, 32'(ef_a), 32'(x_ef[0]), 32'h200);
    lit("r041_sticky", 0, 32'(es_a), 32'(x_es[0]), 32'h2);
    lit("r041_fch", 0, 32'(fch_a), 32'(x_fch[0]), 1);

    do_rst();
    step("r042_push", 2'b01, 2'b00, 16'h00A1, 16'h0000, 2'b11, 2'b00);
    step("r042_push", 2'b01, 2'b00, 16'h00A2, 16'h00A1, 2'b10, 2'b00);
    step("r042_push", 2'b01, 2'b00, 16'h00A3, 16'h00A1, 2'b10, 2'b00);
    step("r042_push", 2'b01, 2'b00, 16'h00A4, 16'h00A1, 2'b10, 2'b00);
    step("r042_pushpop", 2'b01, 2'b01, 16'h0077, 16'h00A1, 2'b10, 2'b01);
    lit("r042_flags", 1, 32'(ef_b), 32'(x_ef[1]), 0);
    lit("r042_level", 1, 32'(lv_b[2:0]), 32'(mq[2].size()), 4);
    step("r042_pop", 2'b00, 2'b01, 16'h0000, 16'h00A2, 2'b10, 2'b01);
    step("r042_pop", 2'b00, 2'b01, 16'h0000, 16'h00A3, 2'b10, 2'b00);
    step("r042_pop", 2'b00, 2'b01, 16'h0000, 16'h00A4, 2'b10, 2'b00);
    step("r042_pop", 2'b00, 2'b01, 16'h0000, 16'h0077, 2'b10, 2'b00);
    lit("r042_sticky", 1, 32'(es_b), 32'(x_es[1]), 0);
    lit("r042_empty", 1, 32'(lv_b), 32'(mq[2].size()), 0);

    do_rst();
    step("r043_both", 2'b00, 2'b11, 16'h0000, 16'h0000, 2'b11, 2'b00);
    lit("r043_fch", 1, 32'(fch_b), 32'(x_fch[1]), 0);
    lit("r043_flags", 1, 32'(ef_b), 32'(x_ef[1]), 32'h042);
    for (int i = 0; i < 4; i++) step("r043_ch1", 2'b00, 2'b10, 16'h0000, 16'h0000, 2'b11, 2'b00);
    lit("r043_fcode", 1, 32'(fc_b), 32'(x_fc[1]), 32'h02);
    lit("r043_fch_kept", 1, 32'(fch_b), 32'(x_fch[1]), 0);
    lit("r043_sat", 1, 32'(cnt_b), 32'(x_cnt[1]), 3);
    lit("r043_cnt8", 0, 32'(cnt_a), 32'(x_cnt[0]), 5);

    do_rst();
    step("r044_strict", 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b11, 2'b01);
    lit("r044_flags", 1, 32'(ef_b), 32'(x_ef[1]), 32'h008);
    lit("r044_nonstrict", 0, 32'(ef_a), 32'(x_ef[0]), 0);
    rst = 1'b1;
    step("r044_reset", 2'b00, 2'b00, 16'h0000, 16'h0000, 2'b11, 2'b01);
    rst = 1'b0;
    lit("r044_clear_flags", 1, 32'(ef_b), 32'(x_ef[1]), 0);
    lit("r044_clear_valid", 1, 32'(fv_b), 32'(x_fv[1]), 0);
    lit("r044_clear_count", 1, 32'(cnt_b), 32'(x_cnt[1]), 0);

    // Randomized traffic; flags and read data mostly track one configuration's model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      int occ;
      r = (i / 500) % ND;
      if (i % 500 == 0) $display("txn random block %0d: reference cfg%0d", i / 500, r);
      rst = ($urandom_range(0, 149) == 0);
      for (int c = 0; c < 2; c++) begin
        occ = mq[r*2+c].size();
        push[c] = ($urandom_range(0, 99) < ((occ >= dep_of(r)) ? 15 : 55));
        pop[c]  = ($urandom_range(0, 99) < ((occ == 0) ? 5 : 45));
        wd[c*8 +: 8] = 8'($urandom);
        emp[c] = (occ == 0) ^ ($urandom_range(0, 99) < 3);
        ful[c] = (occ == dep_of(r)) ^ ($urandom_range(0, 99) < 3);
        rd[c*8 +: 8] = (occ > 0) ? mq[r*2+c][0] : 8'($urandom);
        if ($urandom_range(0, 99) < 3) rd[c*8 +: 8] = rd[c*8 +: 8] ^ 8'h10;
      end
      cycle();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_multi_checker.md
FIFO_MULTI_CHECKER -- requirements
Module: fifo_multi_checker

Interface
REQ-001 Parameter: width, 8, data bits per channel.
REQ-002 Parameter: depth, 4, entries per monitored FIFO; legal values are 2..64.
REQ-003 Parameter: n_ch, 2, number of independent FIFO channels; legal values are 1..8.
REQ-004 Parameter: allow_push_when_full_with_pop, 0, when 1 a push while full is legal if pop is asserted in the same cycle.
REQ-005 Parameter: strict, 0, when 1 empty and full SHALL exactly equal model occupancy==0 and occupancy==depth.
REQ-006 Parameter: cnt_w, 8, width of the error counter.
REQ-007 Port: clk  in  1  clock, all logic on posedge.
REQ-008 Port: rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-009 Port: push  in  n_ch  per-channel push strobe.
REQ-010 Port: pop  in  n_ch  per-channel pop strobe.
REQ-011 Port: write_data  in  n_ch*width  flattened; channel c occupies bits [c*width +: width].
REQ-012 Port: read_data  in  n_ch*width  flattened, same packing.
REQ-013 Port: empty  in  n_ch  DUT empty flags.
REQ-014 Port: full  in  n_ch  DUT full flags.
REQ-015 Port: err_flags  out  n_ch*5  registered per-channel error vector for the previous cycle; bit0 overflow, bit1 underflow, bit2 empty mismatch, bit3 full mismatch, bit4 data mismatch.
REQ-016 Port: err_sticky  out  n_ch  per-channel OR of all errors since reset.
REQ-017 Port: first_err_valid  out  1  high once any error has been captured.
REQ-018 Port: first_err_ch  out  $clog2(n_ch) (minimum 1)  channel of the first error.
REQ-019 Port: first_err_code  out  5  error vector of the first error.
REQ-020 Port: err_count  out  cnt_w  saturating count of cycles with any error.
REQ-021 Port: level  out  n_ch*$clog2(depth+1)  registered model occupancy per channel.

Function
REQ-022 Each channel SHALL hold a shadow model: a circular buffer of depth entries with read pointer, write pointer and count; pointers wrap from depth-1 to 0 for non-power-of-2 depth.
REQ-023 All checks in a cycle SHALL use the model state before that cycle's update; the model update SHALL follow in the same clock edge.
REQ-024 Overflow SHALL flag on push & full & ~(pop & allow_push_when_full_with_pop).
REQ-025 Underflow SHALL flag on pop & empty.
REQ-026 Empty mismatch SHALL flag on count==0 & ~empty; when strict=1, it SHALL also flag on count!=0 & empty.
REQ-027 Full mismatch SHALL flag on count==depth & ~full; when strict=1, it SHALL also flag on count!=depth & full.
REQ-028 Data mismatch SHALL flag on ~empty & count!=0 & read_data != model head entry.
REQ-029 The model SHALL pop when pop & count>0.
REQ-030 The model SHALL push write_data when push & (count<depth | (pop & count>0)); a push into a full model without a pop is dropped and counts only as overflow.
REQ-031 On simultaneous push and pop with count>0, count SHALL be unchanged and both pointers SHALL advance; with count==0, only the push SHALL take effect.
REQ-032 err_flags SHALL appear one cycle after the offending inputs; err_sticky, err_count, first_err_* and level SHALL update on the same edge.
REQ-033 first_err_* SHALL be captured only when first_err_valid is 0; on a same-cycle tie, the lowest-numbered channel SHALL win.
REQ-034 err_count SHALL increment by 1 per cycle with any error on any channel and SHALL saturate at all-ones.
REQ-035 Channels SHALL be fully independent except for the shared first-error capture and err_count.

Reset
REQ-036 When rst=1 at an edge, all counts, pointers, err_flags, err_sticky, first_err_valid, first_err_ch, first_err_code, err_count and level SHALL be cleared to 0; buffer contents need not be cleared.
REQ-037 Checking SHALL be disabled until the first rst edge after power-up; before that, all outputs SHALL stay 0 and the model SHALL not update.
REQ-038 rst asserted mid-traffic SHALL discard in-flight model contents; the cycle after rst deasserts is checked against an empty model.

Verification
REQ-039 depth=4, ch0: push 0xA1,0xA2,0xA3 with DUT flags correct -> no errors, level[ch0]=3.
REQ-040 Push to full ch0 (4 entries), then push 0x55 with full=1 and pop=0 -> err_flags[ch0] bit0 next cycle, first_err_ch=0, first_err_code=5'b00001, err_count=1, level stays 4.
REQ-041 ch1 holds 0x10 at the head, DUT presents read_data=0x11 with empty=0 -> bit4 set on ch1, err_sticky=2'b10.
REQ-042 allow_push_when_full_with_pop=1, ch0 full, push 0x77 and pop in the same cycle -> no error, level stays 4, 0x77 becomes the tail entry.
REQ-043 Errors on ch0 and ch1 in the same cycle -> first_err_ch=0; a later error leaves first_err_* unchanged; with cnt_w=2, five error cycles give err_count=3.
REQ-044 strict=1, empty model, DUT reports empty=1 and full=1 -> bit3 set, bit2 clear; then rst -> all outputs 0 the next cycle.
